hmcs_timer_irq_ctrl: RTL and testbench
======================================

// Module: hmcs_timer_irq_ctrl
// PURPOSE
//   Parametrised timer/counter and interrupt controller for the HMCS4x MCU family.
//   Generalises the single 4-bit timer/counter and fixed two-input interrupt logic to
//   NUM_TMR channels and NUM_EXT external lines, with a prioritised request/ack handshake.
//   Sits beside the core: the core issues commands, reads counters and vectors on irq_req.
// PARAMETERS
//   NUM_TMR  2  timer/counter channels, 1..4
//   NUM_EXT  2  external interrupt inputs, 1..4
//   CNT_W    4  counter width, bits
//   PRE_W    6  prescaler width; one timer tick per 2^PRE_W MCU ticks
// PORTS
//   clk        in   1                clock clk
//   reset      in   1                reset reset, synchronous, active-high
//   tick_en    in   1                MCU-cycle enable; all state except sync FFs advances only here
//   ext_in     in   NUM_EXT          async external interrupt lines
//   cnt_in     in   NUM_TMR          async event inputs, counter mode
//   cmd_valid  in   1                command strobe, sampled when tick_en=1
//   cmd_op     in   3                0 LOAD,1 MODE,2 MASK,3 UNMASK,4 SETIE,5 CLRIE,6 CLRFLAG
//   cmd_idx    in   3                channel (LOAD/MODE) or source index (MASK/UNMASK/CLRFLAG)
//   cmd_data   in   CNT_W            LOAD value; MODE: bit0 1=counter,0=timer
//   cnt_q      out  NUM_TMR*CNT_W    counter values, channel 0 in LSBs
//   flags      out  NSRC             sticky flags; NSRC=NUM_EXT+NUM_TMR
//   irq_req    out  1                interrupt request, held until irq_ack
//   irq_id     out  3                source index of the pending request
//   irq_ack    in   1                one-clk ack; sampled on any clk
// BEHAVIOUR
//   Sources: 0..NUM_EXT-1 external; NUM_EXT+i timer channel i. Lower index = higher priority.
//   Reset values: counters 0, prescalers 0, mode timer, masks all 1, flags 0, IE 0,
//     irq_req 0, irq_id 0, sync/edge FFs 0. Reset mid-request drops irq_req next clk.
//   ext_in/cnt_in: 2-FF synchroniser on every clk. Edge register updates on tick_en only.
//     A rising edge is sync=1 and prev=0 at a tick. Pulses shorter than a tick may be missed.
//   Timer mode: prescaler increments each tick. Wrap from all-ones to 0 yields one event.
//   Counter mode: each cnt_in rising edge yields one event; the prescaler still runs.
//   Event: counter+1 mod 2^CNT_W. Wrap from all-ones to 0 sets the timer flag.
//   LOAD: counter<=cmd_data and prescaler<=0 that tick. LOAD beats a same-tick event,
//     and no flag is set.
//   MODE: changes the event source only. Counter is kept and prescaler<=0.
//   ext rising edge sets its flag. Flags are sticky until CLRFLAG or ack.
//     A set beats a same-tick clear.
//   pending = flags & ~mask. At a tick with IE=1, irq_req=0 and pending!=0:
//     irq_req<=1, irq_id<=lowest pending index, IE<=0 (auto-disable). Response is next tick.
//   irq_ack with irq_req=1: irq_req<=0 and flags[irq_id]<=0 next clk, unless re-set that clk.
//     irq_ack with irq_req=0 is ignored. IE stays 0 until SETIE.
//   SETIE in the same tick as a pending source: IE=1 is visible from the next tick.
//   Commands take effect at the tick where cmd_valid=1, one per tick.
//     cmd_idx out of range or undefined cmd_op: no effect.
//   Counter visible on cnt_q the clk after update. No combinational input-to-output paths.
// STRUCTURE
//   Package hmcs_tmr_pkg: cmd_op localparams, source-index helper function, IDX_W=3.
//   Sub-module hmcs_tmr_chan (prescaler, edge detect, counter, wrap flag) x NUM_TMR via generate.
//   Top level holds ext sync/edge logic, mask/flag/IE registers and the priority encoder.
// TESTING
//   1 Timer, PRE_W=6, LOAD 4'hE, UNMASK src 2, SETIE -> flag[2] after 128 ticks;
//     irq_req=1, irq_id=2 on the next tick; IE=0.
//   2 ext_in[0] and ext_in[1] rise in the same tick, both unmasked, IE=1 -> irq_id=0.
//     Ack, then SETIE -> irq_id=1.
//   3 Counter mode ch1, LOAD 4'hD, 3 cnt_in pulses -> cnt_q ch1 = 0, flag[3]=1.
//     A 4th pulse -> 1.
//   4 LOAD in the same tick as a wrap event -> counter=cmd_data, flag unchanged, prescaler=0.
//   5 ext edge in the same clk as irq_ack of that source -> flag stays 1, irq_req goes 0.
//   6 reset asserted while irq_req=1 and counters nonzero -> all outputs at reset values next clk.

Source files
------------

// File: rtl/hmcs_tmr_pkg.sv
// Shared definitions for the HMCS4x timer/counter and interrupt controller:
// command opcodes, source-index width and the timer source-index mapping.
package hmcs_tmr_pkg;

    localparam int IDX_W = 3;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_MODE    = 3'd1;
    localparam logic [2:0] OP_MASK    = 3'd2;
    localparam logic [2:0] OP_UNMASK  = 3'd3;
    localparam logic [2:0] OP_SETIE   = 3'd4;
    localparam logic [2:0] OP_CLRIE   = 3'd5;
    localparam logic [2:0] OP_CLRFLAG = 3'd6;

    // Timer channel i owns the interrupt source directly after the external lines.
    function automatic int tmr_src(input int num_ext, input int chan);
        return num_ext + chan;
    endfunction

endpackage

// File: rtl/hmcs_tmr_chan.sv
// One timer/counter channel: event-input synchroniser and edge detect,
// free-running prescaler, counter and the one-tick wrap strobe.
module hmcs_tmr_chan
    import hmcs_tmr_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int PRE_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick_en,
    input  logic             i_cnt_in,
    input  logic             i_load,
    input  logic             i_mode_wr,
    input  logic [CNT_W-1:0] i_data,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             r_mode;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_cnt;

    logic w_edge;
    logic w_event;

    assign w_edge  = r_sync2 & ~r_prev;
    assign w_event = r_mode ? w_edge : (&r_pre);

    // A LOAD overrides the event of the same tick, so no wrap is reported then.
    assign o_wrap = i_tick_en & ~i_load & w_event & (&r_cnt);
    assign o_cnt  = r_cnt;

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking assignments would let later statements see the updated values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_mode  <= 1'b0;
            r_pre   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_cnt_in;
            r_sync2 <= r_sync1;
            if (i_tick_en) begin
                r_prev <= r_sync2;
                if (i_load) begin
                    r_cnt <= i_data;
                    r_pre <= '0;
                end else begin
                    r_pre <= i_mode_wr ? '0 : r_pre + 1'b1;
                    if (i_mode_wr)
                        r_mode <= i_data[0];
                    if (w_event)
                        r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hmcs_timer_irq_ctrl.sv
// Timer/counter and prioritised interrupt controller: external line synchronisers,
// mask/flag/IE registers, priority encoder and the irq_req/irq_ack handshake.
module hmcs_timer_irq_ctrl
    import hmcs_tmr_pkg::*;
#(
    parameter int NUM_TMR = 2,
    parameter int NUM_EXT = 2,
    parameter int CNT_W   = 4,
    parameter int PRE_W   = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick_en,
    input  logic [NUM_EXT-1:0]       ext_in,
    input  logic [NUM_TMR-1:0]       cnt_in,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd_op,
    input  logic [2:0]               cmd_idx,
    input  logic [CNT_W-1:0]         cmd_data,
    output logic [NUM_TMR*CNT_W-1:0] cnt_q,
    output logic [NUM_EXT+NUM_TMR-1:0] flags,
    output logic                     irq_req,
    output logic [IDX_W-1:0]         irq_id,
    input  logic                     irq_ack
);

    localparam int NSRC = NUM_EXT + NUM_TMR;

    logic [NUM_EXT-1:0] r_ext_s1;
    logic [NUM_EXT-1:0] r_ext_s2;
    logic [NUM_EXT-1:0] r_ext_prev;
    logic [NSRC-1:0]    r_mask;
    logic [NSRC-1:0]    r_flags;
    logic               r_ie;
    logic               r_irq_req;
    logic [IDX_W-1:0]   r_irq_id;

    logic               w_cmd_tick;
    logic               w_ack;
    logic [NUM_TMR-1:0] w_tmr_wrap;
    logic [NSRC-1:0]    w_set;
    logic [NSRC-1:0]    w_clr;
    logic [NSRC-1:0]    w_mask_set;
    logic [NSRC-1:0]    w_mask_clr;
    logic [NSRC-1:0]    w_pend;
    logic               w_any;
    logic [IDX_W-1:0]   w_low_id;

    assign w_cmd_tick = tick_en & cmd_valid;
    assign w_ack      = r_irq_req & irq_ack;

    for (genvar i = 0; i < NUM_TMR; i++) begin : g_chan
        localparam int SRC = tmr_src(NUM_EXT, i);

        hmcs_tmr_chan #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_tick_en (tick_en),
            .i_cnt_in  (cnt_in[i]),
            .i_load    (w_cmd_tick && cmd_op == OP_LOAD && cmd_idx == IDX_W'(i)),
            .i_mode_wr (w_cmd_tick && cmd_op == OP_MODE && cmd_idx == IDX_W'(i)),
            .i_data    (cmd_data),
            .o_cnt     (cnt_q[i*CNT_W +: CNT_W]),
            .o_wrap    (w_tmr_wrap[i])
        );

        assign w_set[SRC] = w_tmr_wrap[i];
    end

    assign w_set[NUM_EXT-1:0] = tick_en ? (r_ext_s2 & ~r_ext_prev) : '0;

    // Index decoding is done by comparison so out-of-range indices match nothing.
    always_comb begin
        w_clr      = '0;
        w_mask_set = '0;
        w_mask_clr = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (cmd_idx == IDX_W'(s) && w_cmd_tick) begin
                w_clr[s]      = (cmd_op == OP_CLRFLAG);
                w_mask_set[s] = (cmd_op == OP_MASK);
                w_mask_clr[s] = (cmd_op == OP_UNMASK);
            end
            if (w_ack && r_irq_id == IDX_W'(s))
                w_clr[s] = 1'b1;
        end
    end

    // Scanning downwards leaves the lowest pending index, i.e. the highest priority.
    always_comb begin
        w_pend   = r_flags & ~r_mask;
        w_any    = |w_pend;
        w_low_id = '0;
        for (int s = NSRC - 1; s >= 0; s--) begin
            if (w_pend[s])
                w_low_id = IDX_W'(s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext_s1   <= '0;
            r_ext_s2   <= '0;
            r_ext_prev <= '0;
            r_mask     <= '1;
            r_flags    <= '0;
            r_ie       <= 1'b0;
            r_irq_req  <= 1'b0;
            r_irq_id   <= '0;
        end else begin
            r_ext_s1 <= ext_in;
            r_ext_s2 <= r_ext_s1;
            if (tick_en)
                r_ext_prev <= r_ext_s2;

            // A set wins over a same-clk clear, whether from CLRFLAG or ack.
            r_flags <= (r_flags & ~w_clr) | w_set;
            r_mask  <= (r_mask & ~w_mask_clr) | w_mask_set;

            if (w_ack)
                r_irq_req <= 1'b0;

            if (tick_en) begin
                if (r_ie && !r_irq_req && w_any) begin
                    r_irq_req <= 1'b1;
                    r_irq_id  <= w_low_id;
                    r_ie      <= 1'b0;
                end else if (w_cmd_tick && cmd_op == OP_SETIE) begin
                    r_ie <= 1'b1;
                end else if (w_cmd_tick && cmd_op == OP_CLRIE) begin
                    r_ie <= 1'b0;
                end
            end
        end
    end

    assign flags   = r_flags;
    assign irq_req = r_irq_req;
    assign irq_id  = r_irq_id;

endmodule

// File: tb/tb_hmcs_timer_irq_ctrl.sv
// Directed bench for hmcs_timer_irq_ctrl: expected interrupt ids go into a scoreboard
// queue checked by a monitor on each irq_req assertion; state is checked directly.
module tb_hmcs_timer_irq_ctrl;

    localparam int NUM_TMR = 2;
    localparam int NUM_EXT = 2;
    localparam int CNT_W   = 4;
    localparam int PRE_W   = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_en;
    logic [1:0] ext_in;
    logic [1:0] cnt_in;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [2:0] cmd_idx;
    logic [3:0] cmd_data;
    logic [7:0] cnt_q;
    logic [3:0] flags;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       irq_ack;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    logic       mon_prev = 1'b0;

    hmcs_timer_irq_ctrl #(
        .NUM_TMR (NUM_TMR),
        .NUM_EXT (NUM_EXT),
        .CNT_W   (CNT_W),
        .PRE_W   (PRE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_en   (tick_en),
        .ext_in    (ext_in),
        .cnt_in    (cnt_in),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .cmd_data  (cmd_data),
        .cnt_q     (cnt_q),
        .flags     (flags),
        .irq_req   (irq_req),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every new irq_req must match the next queued id.
    always @(negedge clk) begin
        if (irq_req === 1'b1 && !mon_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL irq_unexpected: got id %0d, expected no request", irq_id);
            end else begin
                mon_exp = exp_q.pop_front();
                if (irq_id !== mon_exp) begin
                    errors++;
                    $display("FAIL irq_id_sb: got %0d, expected %0d", irq_id, mon_exp);
                end
            end
        end
        mon_prev = irq_req;
    end

    // One tick = two clks; the tick edge is the second posedge, outputs are read after it.
    task automatic do_tick(input logic v, input logic [2:0] op, input logic [2:0] idx,
                           input logic [3:0] d);
        @(negedge clk);
        tick_en   = 1'b1;
        cmd_valid = v;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_data  = d;
        @(negedge clk);
        tick_en   = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) do_tick(1'b0, 3'd0, 3'd0, 4'd0);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [2:0] idx, input logic [3:0] d);
        do_tick(1'b1, op, idx, d);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_cnt1();
        cnt_in[1] = 1'b1;
        idle(3);
        cnt_in[1] = 1'b0;
        idle(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; tick_en = 1'b0; ext_in = '0; cnt_in = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_data = '0; irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_cnt_q", cnt_q, 8'h00);
        check("rst_flags", flags, 4'h0);
        check("rst_irq_req", irq_req, 1'b0);
        check("rst_irq_id", irq_id, 3'd0);

        // Test 1: timer ch0 from 0xE wraps after 128 ticks; ch1 free-runs from reset.
        cmd(3'd0, 3'd0, 4'hE);
        cmd(3'd3, 3'd2, 4'h0);
        cmd(3'd4, 3'd0, 4'h0);
        exp_q.push_back(3'd2);
        idle(125);
        check("t1_cnt_tick127", cnt_q, 8'h2F);
        check("t1_flags_tick127", flags, 4'h0);
        idle(1);
        check("t1_cnt_wrap", cnt_q, 8'h20);
        check("t1_flag2_set", flags, 4'h4);
        check("t1_req_not_yet", irq_req, 1'b0);
        idle(1);
        check("t1_req", irq_req, 1'b1);
        check("t1_id", irq_id, 3'd2);
        ack();
        check("t1_ack_req", irq_req, 1'b0);
        check("t1_ack_flags", flags, 4'h0);
        cmd(3'd2, 3'd2, 4'h0);

        // Test 2: simultaneous external edges; lower index wins, then the other.
        cmd(3'd3, 3'd0, 4'h0);
        cmd(3'd3, 3'd1, 4'h0);
        cmd(3'd4, 3'd0, 4'h0);
        exp_q.push_back(3'd0);
        ext_in = 2'b11;
        idle(2);
        check("t2_flags", flags, 4'h3);
        check("t2_req_not_yet", irq_req, 1'b0);
        idle(1);
        check("t2_req0", irq_req, 1'b1);
        check("t2_id0", irq_id, 3'd0);
        ack();
        check("t2_ack0_flags", flags, 4'h2);
        check("t2_ack0_req", irq_req, 1'b0);
        exp_q.push_back(3'd1);
        cmd(3'd4, 3'd0, 4'h0);
        check("t2_setie_req", irq_req, 1'b0);
        idle(1);
        check("t2_id1", irq_id, 3'd1);
        ack();
        check("t2_ack1_flags", flags, 4'h0);

        // Test 5: external edge on the same clk as the ack of that source.
        ext_in = 2'b00;
        idle(3);
        cmd(3'd4, 3'd0, 4'h0);
        exp_q.push_back(3'd0);
        ext_in = 2'b01;
        idle(3);
        check("t5_req", irq_req, 1'b1);
        ext_in = 2'b00;
        idle(3);
        ext_in = 2'b01;
        @(negedge clk);
        @(negedge clk);
        tick_en = 1'b1;
        irq_ack = 1'b1;
        @(negedge clk);
        tick_en = 1'b0;
        irq_ack = 1'b0;
        check("t5_flag_kept", flags, 4'h1);
        check("t5_req_dropped", irq_req, 1'b0);
        idle(2);
        check("t5_ie_auto_off", irq_req, 1'b0);
        cmd(3'd6, 3'd7, 4'h0);
        check("t5_clr_oob", flags, 4'h1);
        cmd(3'd6, 3'd0, 4'h0);
        check("t5_clrflag", flags, 4'h0);

        // Test 3: ch1 counter mode, 0xD plus three events wraps to 0.
        cmd(3'd1, 3'd1, 4'h1);
        cmd(3'd0, 3'd1, 4'hD);
        check("t3_load", cnt_q[7:4], 4'hD);
        repeat (3) pulse_cnt1();
        check("t3_cnt_wrap", cnt_q[7:4], 4'h0);
        check("t3_flag3", flags, 4'h8);
        pulse_cnt1();
        check("t3_cnt_4th", cnt_q[7:4], 4'h1);
        idle(64);
        check("t3_no_timer_evt", cnt_q[7:4], 4'h1);
        cmd(3'd6, 3'd3, 4'h0);
        check("t3_clrflag", flags, 4'h0);
        cmd(3'd7, 3'd1, 4'h9);
        check("t3_bad_op", cnt_q[7:4], 4'h1);
        cmd(3'd0, 3'd5, 4'h9);
        check("t3_bad_idx", cnt_q[7:4], 4'h1);

        // Test 4: LOAD on the wrap tick beats the event; LOAD restarts the prescaler.
        cmd(3'd0, 3'd0, 4'hF);
        idle(63);
        cmd(3'd0, 3'd0, 4'h5);
        check("t4_load_wins", cnt_q[3:0], 4'h5);
        check("t4_no_flag", flags, 4'h0);
        idle(63);
        check("t4_cnt_hold", cnt_q[3:0], 4'h5);
        idle(1);
        check("t4_cnt_inc", cnt_q[3:0], 4'h6);
        idle(20);
        cmd(3'd0, 3'd0, 4'h2);
        idle(63);
        check("t4_pre_reset_hold", cnt_q[3:0], 4'h2);
        idle(1);
        check("t4_pre_reset_inc", cnt_q[3:0], 4'h3);

        // Test 6: reset while a request is pending and counters are nonzero.
        ext_in = 2'b00;
        idle(3);
        cmd(3'd4, 3'd0, 4'h0);
        exp_q.push_back(3'd0);
        ext_in = 2'b01;
        idle(3);
        check("t6_req_before", irq_req, 1'b1);
        check("t6_cnt_before", cnt_q, 8'h13);
        reset  = 1'b1;
        ext_in = 2'b00;
        @(negedge clk);
        reset  = 1'b0;
        check("t6_cnt_q", cnt_q, 8'h00);
        check("t6_flags", flags, 4'h0);
        check("t6_irq_req", irq_req, 1'b0);
        check("t6_irq_id", irq_id, 3'd0);

        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
